// File: rtl/hazard_ctrl.sv
// Hazard controller beside the ID stage. It tracks the destination tags in EX/MEM/WB,
// drives the RegFile bypass, stalls IF/ID on load-use and flushes on a taken branch.
module hazard_ctrl #(
    parameter int unsigned LOAD_STALL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rd,
    input  logic        id_wr_en,
    input  logic        id_is_load,
    input  logic [31:0] ex_result,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] wb_wdata,
    input  logic        ex_branch_taken,
    output logic        risk_con1,
    output logic        risk_con2,
    output logic [31:0] risk_rd1,
    output logic [31:0] risk_rd2,
    output logic        stall_if,
    output logic        stall_id,
    output logic        flush_if_id,
    output logic        flush_id_ex
);

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } tag_t;

    typedef enum logic {StRun, StStall} state_e;

    tag_t       ex_t, mem_t, wb_t, ex_t_d;
    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       rst_q;
    logic       hold, hit, stall, flush;
    logic [32:0] fwd1, fwd2;

    // A load in EX has no data yet, so it is skipped and an older stage may match.
    function automatic logic [32:0] fwd_sel(input logic used, input logic [4:0] src,
                                            input tag_t ex, input tag_t mem, input tag_t wb,
                                            input logic [31:0] exd, input logic [31:0] memd,
                                            input logic [31:0] wbd);
        fwd_sel = '0;
        if (used && src != 5'd0) begin
            if (ex.v && !ex.ld && ex.rd == src) begin
                fwd_sel = {1'b1, exd};
            end else if (mem.v && mem.rd == src) begin
                fwd_sel = {1'b1, memd};
            end else if (wb.v && wb.rd == src) begin
                fwd_sel = {1'b1, wbd};
            end
        end
    endfunction

    always_comb begin
        hold  = rst | rst_q;
        fwd1  = fwd_sel(id_rs1_used, id_rs1, ex_t, mem_t, wb_t, ex_result, mem_wdata, wb_wdata);
        fwd2  = fwd_sel(id_rs2_used, id_rs2, ex_t, mem_t, wb_t, ex_result, mem_wdata, wb_wdata);
        hit   = id_valid && ex_t.v && ex_t.ld &&
                ((id_rs1_used && id_rs1 != 5'd0 && ex_t.rd == id_rs1) ||
                 (id_rs2_used && id_rs2 != 5'd0 && ex_t.rd == id_rs2));
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        flush   = 1'b0;
        if (ex_branch_taken) begin
            flush   = 1'b1;
            state_d = StRun;
            cnt_d   = 2'd0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (hit) begin
                        stall   = 1'b1;
                        cnt_d   = 2'(LOAD_STALL - 1);
                        state_d = (LOAD_STALL > 1) ? StStall : StRun;
                    end
                end
                StStall: begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
        // Outputs stay quiet during reset and the cycle after it.
        if (hold) begin
            stall   = 1'b0;
            flush   = 1'b0;
            fwd1    = '0;
            fwd2    = '0;
            state_d = StRun;
            cnt_d   = 2'd0;
        end
        risk_con1   = fwd1[32];
        risk_rd1    = fwd1[31:0];
        risk_con2   = fwd2[32];
        risk_rd2    = fwd2[31:0];
        stall_if    = stall;
        stall_id    = stall;
        flush_if_id = flush;
        flush_id_ex = flush;
        if (stall || flush) begin
            ex_t_d = '0;
        end else begin
            ex_t_d = '{v: id_valid & id_wr_en & (id_rd != 5'd0), rd: id_rd, ld: id_is_load};
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            ex_t    <= '0;
            mem_t   <= '0;
            wb_t    <= '0;
            state_q <= StRun;
            cnt_q   <= 2'd0;
        end else begin
            ex_t    <= ex_t_d;
            mem_t   <= ex_t;
            wb_t    <= mem_t;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (LOAD_STALL=1 and 3) share stimulus;
// each vector selects which instance its hand-computed expectation applies to.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst, id_valid, id_rs1_used, id_rs2_used, id_wr_en, id_is_load, ex_branch_taken;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] ex_result, mem_wdata, wb_wdata;

    logic        a_con1, a_con2, a_sif, a_sid, a_fif, a_fex;
    logic [31:0] a_rd1, a_rd2;
    logic        b_con1, b_con2, b_sif, b_sid, b_fif, b_fex;
    logic [31:0] b_rd1, b_rd2;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL(1)) u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .ex_result(ex_result),
        .mem_wdata(mem_wdata), .wb_wdata(wb_wdata), .ex_branch_taken(ex_branch_taken),
        .risk_con1(a_con1), .risk_con2(a_con2), .risk_rd1(a_rd1), .risk_rd2(a_rd2),
        .stall_if(a_sif), .stall_id(a_sid), .flush_if_id(a_fif), .flush_id_ex(a_fex)
    );

    hazard_ctrl #(.LOAD_STALL(3)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .ex_result(ex_result),
        .mem_wdata(mem_wdata), .wb_wdata(wb_wdata), .ex_branch_taken(ex_branch_taken),
        .risk_con1(b_con1), .risk_con2(b_con2), .risk_rd1(b_rd1), .risk_rd2(b_rd2),
        .stall_if(b_sif), .stall_id(b_sid), .flush_if_id(b_fif), .flush_id_ex(b_fex)
    );

    typedef struct {
        int          id;
        logic        sel;
        logic [69:0] exp;
    } item_t;

    item_t sb[$];
    int    compared   = 0;
    int    mismatched = 0;
    localparam logic [69:0] Z = '0;

    function automatic logic [69:0] pk(input logic c1, input logic [31:0] d1, input logic c2,
                                       input logic [31:0] d2, input logic st, input logic fl);
        return {c1, c2, st, st, fl, fl, d1, d2};
    endfunction

    task automatic step(input int id, input logic sel, input logic r, input logic br,
                        input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld, input logic [31:0] exd,
                        input logic [31:0] md, input logic [31:0] wd, input logic [69:0] e);
        item_t it;
        @(posedge clk);
        #1;
        rst = r; ex_branch_taken = br; id_valid = v;
        id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_wr_en = we; id_is_load = ld;
        ex_result = exd; mem_wdata = md; wb_wdata = wd;
        it.id = id; it.sel = sel; it.exp = e;
        sb.push_back(it);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            item_t       it;
            logic [69:0] act;
            it  = sb.pop_front();
            act = it.sel ? {b_con1, b_con2, b_sif, b_sid, b_fif, b_fex, b_rd1, b_rd2}
                         : {a_con1, a_con2, a_sif, a_sid, a_fif, a_fex, a_rd1, a_rd2};
            compared++;
            if (act !== it.exp) begin
                mismatched++;
                $display("FAIL vec%0d dut%0d outputs got=%h exp=%h", it.id, it.sel, act, it.exp);
            end
        end
    end

    initial begin
        rst = 1'b1; ex_branch_taken = 1'b0; id_valid = 1'b0;
        id_rs1 = '0; id_rs1_used = 1'b0; id_rs2 = '0; id_rs2_used = 1'b0;
        id_rd = '0; id_wr_en = 1'b0; id_is_load = 1'b0;
        ex_result = '0; mem_wdata = '0; wb_wdata = '0;
        // Reset and the cycle after: outputs quiet even with a branch asserted
        step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z);
        step(2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z);
        // EX bypass, then youngest-wins
        step(3, 0, 0, 0, 1, 0, 0, 0, 0, 5, 1, 0, 32'h1234, 0, 0, Z);
        step(4, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 32'h1234, 0, 0, pk(1, 32'h1234, 0, 0, 0, 0));
        step(5, 0, 0, 0, 1, 5, 1, 0, 0, 5, 1, 0, 32'hA, 32'hB, 0, pk(1, 32'hB, 0, 0, 0, 0));
        step(6, 0, 0, 0, 1, 5, 1, 0, 0, 5, 1, 0, 32'hA, 32'hB, 0, pk(1, 32'hA, 0, 0, 0, 0));
        step(7, 0, 0, 0, 1, 5, 1, 5, 1, 0, 0, 0, 32'hA, 32'hB, 0, pk(1, 32'hA, 1, 32'hA, 0, 0));
        // x0 never bypassed
        step(8, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 32'hFFFF, 32'hFFFF, 32'hFFFF, Z);
        step(9, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 32'hFFFF, 32'hFFFF, 32'hFFFF, Z);
        // Load-use, LOAD_STALL=1
        step(10, 0, 0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 32'hDEADBEEF, 0, Z);
        step(11, 0, 0, 0, 1, 0, 0, 7, 1, 8, 1, 0, 0, 32'hDEADBEEF, 0, pk(0, 0, 0, 0, 1, 0));
        step(12, 0, 0, 0, 1, 0, 0, 7, 1, 8, 1, 0, 0, 32'hDEADBEEF, 0,
             pk(0, 0, 1, 32'hDEADBEEF, 0, 0));
        step(13, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z);
        step(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z);
        // Load-use, LOAD_STALL=3: exactly three stall cycles
        step(15, 1, 0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 32'hDEADBEEF, 32'hCAFEF00D, Z);
        step(16, 1, 0, 0, 1, 0, 0, 7, 1, 8, 1, 0, 0, 32'hDEADBEEF, 32'hCAFEF00D,
             pk(0, 0, 0, 0, 1, 0));
        step(17, 1, 0, 0, 1, 0, 0, 7, 1, 8, 1, 0, 0, 32'hDEADBEEF, 32'hCAFEF00D,
             pk(0, 0, 1, 32'hDEADBEEF, 1, 0));
        step(18, 1, 0, 0, 1, 0, 0, 7, 1, 8, 1, 0, 0, 32'hDEADBEEF, 32'hCAFEF00D,
             pk(0, 0, 1, 32'hCAFEF00D, 1, 0));
        step(19, 1, 0, 0, 1, 0, 0, 7, 1, 8, 1, 0, 0, 32'hDEADBEEF, 32'hCAFEF00D, Z);
        // Branch beats load-use
        step(20, 0, 0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 32'h5555AAAA, 0, Z);
        step(21, 0, 0, 1, 1, 0, 0, 7, 1, 8, 1, 0, 0, 32'h5555AAAA, 0, pk(0, 0, 0, 0, 0, 1));
        step(22, 0, 0, 0, 1, 0, 0, 7, 1, 8, 1, 0, 0, 32'h5555AAAA, 0,
             pk(0, 0, 1, 32'h5555AAAA, 0, 0));
        // Reset in the middle of a 3-cycle stall
        step(23, 1, 0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 32'h11, 32'h22, 32'h33, Z);
        step(24, 1, 0, 0, 1, 7, 1, 0, 0, 8, 1, 0, 32'h11, 32'h22, 32'h33, pk(0, 0, 0, 0, 1, 0));
        step(25, 1, 1, 0, 1, 7, 1, 0, 0, 8, 1, 0, 32'h11, 32'h22, 32'h33, Z);
        step(26, 1, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 32'h11, 32'h22, 32'h33, Z);
        step(27, 1, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 32'h11, 32'h22, 32'h33, Z);
        step(28, 1, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 32'h11, 32'h22, 32'h33, Z);
        repeat (4) @(posedge clk);
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
